// File: rtl/nibble_countdown_pkg.sv
// Shared constants for the nibble countdown timer: state encodings and default width.
package nibble_countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_countdown_if.sv
// Request/status bundle between a sequencer (master) and the countdown timer (slave).
interface nibble_countdown_if
  import nibble_countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             abort;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             is_zero;

  modport master (
    output start, load_value, abort, ack,
    input  count, busy, done, is_zero
  );

  modport slave (
    input  start, load_value, abort, ack,
    output count, busy, done, is_zero
  );

endinterface

// File: rtl/nibble_countdown_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles; clear restarts the phase.
module nibble_countdown_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] preR;
  logic [PW-1:0] preNextS;

  assign tick = enable && (preR == LAST);

  // Next prescaler phase: clear dominates, wrap on tick, otherwise advance while enabled.
  always_comb begin
    preNextS = preR;
    if (clear) begin
      preNextS = {PW{1'b0}};
    end else if (tick) begin
      preNextS = {PW{1'b0}};
    end else if (enable) begin
      preNextS = preR + PW'(1);
    end else begin
      preNextS = preR;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preR <= {PW{1'b0}};
    end else begin
      preR <= preNextS;
    end
  end

endmodule

// File: rtl/nibble_countdown.sv
// Loadable prescaled down-counter with a done/ack handshake for sequencing delays.
module nibble_countdown
  import nibble_countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  nibble_countdown_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       stateR;
  logic [1:0]       stateNextS;
  logic [WIDTH-1:0] countR;
  logic [WIDTH-1:0] countNextS;
  logic             tickS;
  logic             preClearS;
  logic             preEnableS;

  // Prescaler only runs in RUN; any other state or an abort pins it to phase 0.
  assign preEnableS = (stateR == ST_RUN);
  assign preClearS  = (stateR != ST_RUN) || bus.abort;

  nibble_countdown_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (preClearS),
    .enable(preEnableS),
    .tick  (tickS)
  );

  // Next-state and next-count decode.
  always_comb begin
    stateNextS = stateR;
    countNextS = countR;
    case (stateR)
      ST_IDLE: begin
        if (bus.start) begin
          countNextS = bus.load_value;
          stateNextS = (bus.load_value != ZERO) ? ST_RUN : ST_DONE;
        end else begin
          stateNextS = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort beats a coincident final tick.
        if (bus.abort) begin
          stateNextS = ST_IDLE;
          countNextS = ZERO;
        end else if (tickS) begin
          countNextS = countR - ONE;
          stateNextS = (countR == ONE) ? ST_DONE : ST_RUN;
        end else begin
          stateNextS = ST_RUN;
        end
      end
      ST_DONE: begin
        countNextS = ZERO;
        if (bus.ack) begin
          stateNextS = ST_IDLE;
        end else begin
          stateNextS = ST_DONE;
        end
      end
      default: begin
        stateNextS = ST_IDLE;
        countNextS = ZERO;
      end
    endcase
  end

  // State and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= ST_IDLE;
      countR <= ZERO;
    end else begin
      stateR <= stateNextS;
      countR <= countNextS;
    end
  end

  assign bus.count   = countR;
  assign bus.busy    = (stateR == ST_RUN);
  assign bus.done    = (stateR == ST_DONE);
  assign bus.is_zero = (countR == ZERO);

endmodule

// File: tb/tb_nibble_countdown.sv
// Directed bench for nibble_countdown: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_nibble_countdown;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  nibble_countdown_if #(.WIDTH(4)) bus1 ();
  nibble_countdown_if #(.WIDTH(4)) bus3 ();

  nibble_countdown #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  nibble_countdown #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared = nCompared + 1;
    if (got !== exp) begin
      nMismatched = nMismatched + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.load_value = 4'd0; bus1.abort = 1'b0; bus1.ack = 1'b0;
    bus3.start = 1'b0; bus3.load_value = 4'd0; bus3.abort = 1'b0; bus3.ack = 1'b0;

    // Reset, then idle with no stimulus.
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_count", 32'(bus1.count), 32'd0);
    checkVal("rst_zero",  32'(bus1.is_zero), 32'd1);
    checkVal("rst_busy",  32'(bus1.busy), 32'd0);
    checkVal("rst_done",  32'(bus1.done), 32'd0);
    checkVal("rst_count3", 32'(bus3.count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkVal("idle_count", 32'(bus1.count), 32'd0);
      checkVal("idle_zero",  32'(bus1.is_zero), 32'd1);
      checkVal("idle_busy",  32'(bus1.busy), 32'd0);
      checkVal("idle_done",  32'(bus1.done), 32'd0);
    end

    // Basic count from 5 at PRESCALE=1.
    bus1.load_value = 4'd5; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checkVal("basic_e0_count", 32'(bus1.count), 32'd5);
    checkVal("basic_e0_busy",  32'(bus1.busy), 32'd1);
    checkVal("basic_e0_zero",  32'(bus1.is_zero), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checkVal("basic_count", 32'(bus1.count), 32'(5 - k));
      checkVal("basic_done",  32'(bus1.done), (k == 5) ? 32'd1 : 32'd0);
      checkVal("basic_busy",  32'(bus1.busy), (k == 5) ? 32'd0 : 32'd1);
    end
    checkVal("basic_zero", 32'(bus1.is_zero), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkVal("basic_hold_done", 32'(bus1.done), 32'd1);
      checkVal("basic_hold_count", 32'(bus1.count), 32'd0);
    end
    bus1.ack = 1'b1;
    step();
    bus1.ack = 1'b0;
    checkVal("basic_ack_done", 32'(bus1.done), 32'd0);
    checkVal("basic_ack_busy", 32'(bus1.busy), 32'd0);

    // Full-range load at PRESCALE=3 with stray start pulses during RUN.
    bus3.load_value = 4'hF; bus3.start = 1'b1;
    step();
    checkVal("pre_e0_count", 32'(bus3.count), 32'd15);
    checkVal("pre_e0_busy",  32'(bus3.busy), 32'd1);
    for (int e = 1; e <= 45; e++) begin
      bus3.start = ((e % 4) == 0);
      bus3.load_value = 4'd3;
      step();
      checkVal("pre_count", 32'(bus3.count), 32'(15 - e / 3));
      checkVal("pre_done",  32'(bus3.done), (e == 45) ? 32'd1 : 32'd0);
      checkVal("pre_busy",  32'(bus3.busy), (e == 45) ? 32'd0 : 32'd1);
    end
    bus3.start = 1'b0;
    bus3.ack = 1'b1;
    step();
    bus3.ack = 1'b0;
    checkVal("pre_ack_done", 32'(bus3.done), 32'd0);

    // Zero load goes straight to DONE without RUN.
    bus1.load_value = 4'd0; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checkVal("zero_done",  32'(bus1.done), 32'd1);
    checkVal("zero_busy",  32'(bus1.busy), 32'd0);
    checkVal("zero_iszero", 32'(bus1.is_zero), 32'd1);
    bus1.ack = 1'b1;
    step();
    bus1.ack = 1'b0;
    checkVal("zero_ack_done", 32'(bus1.done), 32'd0);

    // Abort colliding with the final tick.
    bus1.load_value = 4'd2; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checkVal("abort_e0_count", 32'(bus1.count), 32'd2);
    step();
    checkVal("abort_e1_count", 32'(bus1.count), 32'd1);
    bus1.abort = 1'b1;
    step();
    bus1.abort = 1'b0;
    checkVal("abort_busy",  32'(bus1.busy), 32'd0);
    checkVal("abort_done",  32'(bus1.done), 32'd0);
    checkVal("abort_count", 32'(bus1.count), 32'd0);
    step();
    checkVal("abort_after_done", 32'(bus1.done), 32'd0);
    checkVal("abort_after_busy", 32'(bus1.busy), 32'd0);

    // ack and start together in DONE: back to IDLE without reload.
    bus1.load_value = 4'd3; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    repeat (3) step();
    checkVal("coll_done", 32'(bus1.done), 32'd1);
    bus1.ack = 1'b1; bus1.start = 1'b1; bus1.load_value = 4'd9;
    step();
    bus1.ack = 1'b0; bus1.start = 1'b0;
    checkVal("coll_done_fall", 32'(bus1.done), 32'd0);
    checkVal("coll_busy", 32'(bus1.busy), 32'd0);
    checkVal("coll_count", 32'(bus1.count), 32'd0);
    step();
    checkVal("coll_idle_busy", 32'(bus1.busy), 32'd0);
    checkVal("coll_idle_count", 32'(bus1.count), 32'd0);
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checkVal("restart_count", 32'(bus1.count), 32'd9);
    checkVal("restart_busy",  32'(bus1.busy), 32'd1);

    // Asynchronous reset mid-RUN at count 7.
    repeat (2) step();
    checkVal("mid_count", 32'(bus1.count), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_rst_count", 32'(bus1.count), 32'd0);
    checkVal("async_rst_busy",  32'(bus1.busy), 32'd0);
    checkVal("async_rst_zero",  32'(bus1.is_zero), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    checkVal("post_rst_busy",  32'(bus1.busy), 32'd0);
    checkVal("post_rst_count", 32'(bus1.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
